// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
//
// Shared definitions for the UART receiver front end.
//   PRESC_8/16/32    supported oversampling ratios
//   BIT_CNT_W        width of the bit-within-frame counter
//   smp_phase_e      which sampling action (if any) the current edge selects
//   decode_prescale  maps a raw PRESCALE value to the effective ratio
//   maj3             3-input majority vote
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int unsigned PRESC_8   = 8;
    localparam int unsigned PRESC_16  = 16;
    localparam int unsigned PRESC_32  = 32;
    localparam int unsigned BIT_CNT_W = 4;

    // Sampling window around mid-bit: first sample, second sample, then the
    // vote taken together with the third sample.
    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_S0   = 2'd1,
        PH_S1   = 2'd2,
        PH_VOTE = 2'd3
    } smp_phase_e;

    // Unsupported ratios fall back to 8 so the counters always have a sane
    // bit period.
    function automatic int unsigned decode_prescale(input int unsigned presc);
        case (presc)
            PRESC_16: return PRESC_16;
            PRESC_32: return PRESC_32;
            default:  return PRESC_8;
        endcase
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// -----------------------------------------------------------------------------
// edge_bit_counter
//
// Counts oversampling edges within a bit period and bits within a frame.
//
// Ports:
//   CLK       in   oversampling clock, rising edge
//   RST       in   synchronous active-low reset
//   CNT_EN    in   1 = count, 0 = hold both counters cleared
//   PRESCALE  in   raw oversampling ratio (width-1 bits)
//   EDGE_CNT  out  edge index within the current bit, 0..P-1
//   BIT_CNT   out  bit index within the frame, wraps 15 -> 0
//   BIT_DONE  out  combinational, high on the last edge of a bit
//   P_EFF     out  decoded effective prescale, zero-extended to width bits
// -----------------------------------------------------------------------------
module edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int width = 7
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CNT_EN,
    input  logic [width-2:0]     PRESCALE,
    output logic [width-1:0]     EDGE_CNT,
    output logic [BIT_CNT_W-1:0] BIT_CNT,
    output logic                 BIT_DONE,
    output logic [width-1:0]     P_EFF
);

    logic [width-1:0] last_edge;

    assign P_EFF     = width'(decode_prescale(32'(PRESCALE)));
    assign last_edge = P_EFF - width'(1);
    assign BIT_DONE  = CNT_EN && (EDGE_CNT == last_edge);

    // NOTE: reset is sampled inside the clocked block (synchronous), and it is
    // tested first so it overrides CNT_EN and any wrap in the same cycle.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register sees pre-edge values regardless of statement order.
            EDGE_CNT <= '0;
            BIT_CNT  <= '0;
        end else if (!CNT_EN) begin
            // Clearing wins over a simultaneous end-of-bit increment.
            EDGE_CNT <= '0;
            BIT_CNT  <= '0;
        end else if (EDGE_CNT == last_edge) begin
            EDGE_CNT <= '0;
            BIT_CNT  <= BIT_CNT + BIT_CNT_W'(1);
        end else begin
            EDGE_CNT <= EDGE_CNT + width'(1);
        end
    end

endmodule

// File: rtl/rx_data_sampler.sv
// -----------------------------------------------------------------------------
// rx_data_sampler
//
// Oversampling front end of the UART receiver. Counts edges/bits through
// edge_bit_counter, takes three line samples around mid-bit and registers
// their majority vote.
//
// Ports:
//   CLK          in   oversampling clock, rising edge
//   RST          in   synchronous active-low reset
//   RX_IN        in   serial line, already synchronised to CLK
//   CNT_EN       in   1 = count edges/bits, 0 = hold counters cleared
//   SMP_EN       in   1 = capture and vote samples
//   PRESCALE     in   oversampling ratio (8, 16, 32; others act as 8)
//   EDGE_CNT     out  edge index within current bit
//   BIT_CNT      out  bit index within frame
//   BIT_DONE     out  pulse on last edge of a bit
//   SAMPLED_BIT  out  registered majority result, 1 after reset (idle line)
//   SMP_VALID    out  one-cycle pulse when SAMPLED_BIT is updated
//   SMP_NOISE    out  one-cycle pulse with SMP_VALID when samples disagree
// -----------------------------------------------------------------------------
module rx_data_sampler
    import uart_rx_pkg::*;
#(
    parameter int width = 7
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RX_IN,
    input  logic                 CNT_EN,
    input  logic                 SMP_EN,
    input  logic [width-2:0]     PRESCALE,
    output logic [width-1:0]     EDGE_CNT,
    output logic [BIT_CNT_W-1:0] BIT_CNT,
    output logic                 BIT_DONE,
    output logic                 SAMPLED_BIT,
    output logic                 SMP_VALID,
    output logic                 SMP_NOISE
);

    logic [width-1:0] p_eff;
    logic [width-1:0] half;
    logic             s0;
    logic             s1;
    smp_phase_e       phase;

    edge_bit_counter #(
        .width (width)
    ) u_counter (
        .CLK      (CLK),
        .RST      (RST),
        .CNT_EN   (CNT_EN),
        .PRESCALE (PRESCALE),
        .EDGE_CNT (EDGE_CNT),
        .BIT_CNT  (BIT_CNT),
        .BIT_DONE (BIT_DONE),
        .P_EFF    (p_eff)
    );

    assign half = p_eff >> 1;

    // Decode the sampling window H-1, H, H+1 from the edge counter.
    always_comb begin
        // NOTE: default assignment first so no path leaves phase unassigned,
        // which would otherwise infer a latch.
        phase = PH_IDLE;
        if (EDGE_CNT == half - width'(1)) begin
            phase = PH_S0;
        end else if (EDGE_CNT == half) begin
            phase = PH_S1;
        end else if (EDGE_CNT == half + width'(1)) begin
            phase = PH_VOTE;
        end
    end

    // The third sample is RX_IN itself at H+1, so the vote lands one cycle
    // later and SAMPLED_BIT is stable from H+2 to the end of the bit.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            s0          <= 1'b1;
            s1          <= 1'b1;
            SAMPLED_BIT <= 1'b1;
            SMP_VALID   <= 1'b0;
            SMP_NOISE   <= 1'b0;
        end else begin
            SMP_VALID <= 1'b0;
            SMP_NOISE <= 1'b0;
            if (SMP_EN) begin
                case (phase)
                    PH_S0:   s0 <= RX_IN;
                    PH_S1:   s1 <= RX_IN;
                    PH_VOTE: begin
                        SAMPLED_BIT <= maj3(s0, s1, RX_IN);
                        SMP_VALID   <= 1'b1;
                        SMP_NOISE   <= !((s0 == s1) && (s1 == RX_IN));
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_data_sampler.sv
module tb_rx_data_sampler;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       CNT_EN;
    logic       SMP_EN;
    logic [5:0] PRESCALE;
    logic [6:0] EDGE_CNT;
    logic [3:0] BIT_CNT;
    logic       BIT_DONE;
    logic       SAMPLED_BIT;
    logic       SMP_VALID;
    logic       SMP_NOISE;

    typedef struct {
        logic       bit_v;
        logic       noise;
        logic [6:0] edge_at;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    rx_data_sampler #(.width(7)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .CNT_EN      (CNT_EN),
        .SMP_EN      (SMP_EN),
        .PRESCALE    (PRESCALE),
        .EDGE_CNT    (EDGE_CNT),
        .BIT_CNT     (BIT_CNT),
        .BIT_DONE    (BIT_DONE),
        .SAMPLED_BIT (SAMPLED_BIT),
        .SMP_VALID   (SMP_VALID),
        .SMP_NOISE   (SMP_NOISE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drive nbits bit periods of length p; mask[e] is RX_IN at edge e.
    // Expected vote and noise are hand-computed by the caller.
    task automatic run_bits(input int p, input logic [31:0] mask, input int nbits,
                            input int bc0, input logic exp_bit, input logic exp_noise);
        int h;
        h = p / 2;
        for (int b = 0; b < nbits; b++) begin
            for (int e = 0; e < p; e++) begin
                check("edge_cnt", 32'(EDGE_CNT), 32'(e));
                check("bit_cnt", 32'(BIT_CNT), 32'((bc0 + b) % 16));
                check("bit_done", 32'(BIT_DONE), 32'(e == p - 1));
                if (e == h + 2 || e == p - 1)
                    check("sampled_bit", 32'(SAMPLED_BIT), 32'(exp_bit));
                RX_IN = mask[e];
                if (e == h + 1)
                    exp_q.push_back('{exp_bit, exp_noise, 7'(h + 2)});
                step();
            end
        end
    endtask

    // Scoreboard monitor: compares every presented vote against the queue.
    always @(negedge CLK) begin
        if (SMP_VALID) begin
            if (exp_q.size() == 0) begin
                check("unexpected_smp_valid", 32'(SMP_VALID), 32'(0));
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check("vote_bit", 32'(SAMPLED_BIT), 32'(x.bit_v));
                check("vote_noise", 32'(SMP_NOISE), 32'(x.noise));
                check("vote_edge", 32'(EDGE_CNT), 32'(x.edge_at));
            end
        end else if (SMP_NOISE) begin
            check("noise_without_valid", 32'(SMP_NOISE), 32'(0));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset dominates enables and a low line.
        RST = 1'b0; RX_IN = 1'b0; CNT_EN = 1'b1; SMP_EN = 1'b1; PRESCALE = 6'd8;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rst_edge_cnt", 32'(EDGE_CNT), 32'(0));
            check("rst_bit_cnt", 32'(BIT_CNT), 32'(0));
            check("rst_sampled_bit", 32'(SAMPLED_BIT), 32'(1));
            check("rst_smp_valid", 32'(SMP_VALID), 32'(0));
        end
        RST = 1'b1; CNT_EN = 1'b0;
        step();

        // P=8, line low: vote 0, clean.
        CNT_EN = 1'b1;
        run_bits(8, 32'h0000_0000, 2, 0, 1'b0, 1'b0);

        // P=16, single glitch at edge 8: samples 1,0,1 -> 1 with noise.
        CNT_EN = 1'b0;
        step();
        PRESCALE = 6'd16; CNT_EN = 1'b1;
        run_bits(16, 32'hFFFF_FEFF, 1, 0, 1'b1, 1'b1);

        // P=32, low at 15,16: samples 0,0,1 -> 0 with noise; 17 bits wraps BIT_CNT.
        CNT_EN = 1'b0;
        step();
        PRESCALE = 6'd32; CNT_EN = 1'b1;
        run_bits(32, 32'hFFFE_7FFF, 17, 0, 1'b0, 1'b1);
        check("bit_cnt_after_wrap", 32'(BIT_CNT), 32'(1));

        // P=8: three low bits, then drop enables at EDGE_CNT=5, BIT_CNT=3.
        CNT_EN = 1'b0;
        step();
        PRESCALE = 6'd8; CNT_EN = 1'b1;
        run_bits(8, 32'h0000_0000, 3, 0, 1'b0, 1'b0);
        for (int e = 0; e < 5; e++) begin
            check("drop_edge_cnt", 32'(EDGE_CNT), 32'(e));
            RX_IN = 1'b1;
            step();
        end
        check("drop_pre_edge", 32'(EDGE_CNT), 32'(5));
        check("drop_pre_bit", 32'(BIT_CNT), 32'(3));
        CNT_EN = 1'b0; SMP_EN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("drop_edge_cleared", 32'(EDGE_CNT), 32'(0));
            check("drop_bit_cleared", 32'(BIT_CNT), 32'(0));
            check("drop_sampled_held", 32'(SAMPLED_BIT), 32'(0));
            check("drop_no_valid", 32'(SMP_VALID), 32'(0));
        end

        // PRESCALE=12 decodes as 8: samples at 3,4,5 = 1,0,1 -> 1 with noise.
        PRESCALE = 6'd12; CNT_EN = 1'b1; SMP_EN = 1'b1;
        run_bits(8, 32'h0000_0028, 1, 0, 1'b1, 1'b1);

        // Mid-frame synchronous reset at EDGE_CNT=4.
        for (int e = 0; e < 4; e++) begin
            RX_IN = 1'b0;
            step();
        end
        check("mid_rst_pre_edge", 32'(EDGE_CNT), 32'(4));
        check("mid_rst_pre_bit", 32'(BIT_CNT), 32'(1));
        RST = 1'b0;
        step();
        check("mid_rst_edge_cnt", 32'(EDGE_CNT), 32'(0));
        check("mid_rst_bit_cnt", 32'(BIT_CNT), 32'(0));
        check("mid_rst_sampled", 32'(SAMPLED_BIT), 32'(1));
        check("mid_rst_valid", 32'(SMP_VALID), 32'(0));
        check("mid_rst_noise", 32'(SMP_NOISE), 32'(0));
        RST = 1'b1;
        run_bits(8, 32'h0000_0000, 1, 0, 1'b0, 1'b0);

        step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_data_sampler.md
# rx_data_sampler

Oversampling front end of the UART receiver. It counts oversampling edges within each bit period and bits within the frame, then takes three samples of the line around mid-bit and majority-votes them. It drives SAMPLED_BIT, EDGE_CNT and BIT_CNT to the receive FSM and to the downstream parity, start and stop checkers; the stop checker reads SAMPLED_BIT at EDGE_CNT == PRESCALE-2.

## Interface
Parameters:
- width, 7: EDGE_CNT width; PRESCALE is width-1 bits.

Ports:
- CLK  in  1  receiver oversampling clock; all state changes on rising edge
- RST  in  1  reset, synchronous, active-low
- RX_IN  in  1  serial line, already synchronised to CLK
- CNT_EN  in  1  from FSM; 1 = count edges/bits, 0 = hold counters cleared
- SMP_EN  in  1  from FSM; 1 = capture and vote samples
- PRESCALE  in  width-1  oversampling ratio; supported 8, 16, 32
- EDGE_CNT  out  width  edge index within current bit, 0..P-1
- BIT_CNT  out  4  bit index within frame
- BIT_DONE  out  1  one-cycle pulse on last edge of a bit
- SAMPLED_BIT  out  1  registered majority result
- SMP_VALID  out  1  one-cycle pulse when SAMPLED_BIT is updated
- SMP_NOISE  out  1  one-cycle pulse with SMP_VALID when the three samples disagree

## Operation
- Effective prescale P = PRESCALE if PRESCALE is 8, 16 or 32; any other value decodes as 8.
- H = P>>1. All compares are zero-extended to width bits.
- PRESCALE must be stable while CNT_EN=1. A change mid-bit takes effect immediately and the current bit is undefined.
- Edge counter:
  - CNT_EN=0: EDGE_CNT <= 0, BIT_CNT <= 0.
  - CNT_EN=1 and EDGE_CNT != P-1: EDGE_CNT increments.
  - CNT_EN=1 and EDGE_CNT == P-1: EDGE_CNT <= 0 and BIT_CNT increments, wrapping 15->0.
- BIT_DONE is combinational: CNT_EN && EDGE_CNT == P-1.
- Sampler (all actions gated by SMP_EN=1):
  - s0 <= RX_IN at EDGE_CNT == H-1.
  - s1 <= RX_IN at EDGE_CNT == H.
  - At EDGE_CNT == H+1: SAMPLED_BIT <= maj(s0, s1, RX_IN); SMP_VALID <= 1; SMP_NOISE <= !(s0==s1 && s1==RX_IN).
- SAMPLED_BIT holds its value between updates, including while SMP_EN=0 or CNT_EN=0.
- SMP_VALID and SMP_NOISE are 0 in every cycle other than the update cycle.
- If SMP_EN falls between H-1 and H+1, there is no update that bit; stale s0/s1 are overwritten next bit.
- Reset values (RST=0 at rising edge): EDGE_CNT=0, BIT_CNT=0, SAMPLED_BIT=1 (idle line), SMP_VALID=0, SMP_NOISE=0, s0=s1=1.
- Reset wins over all other inputs, including mid-frame.

## Timing
- SAMPLED_BIT is valid from the cycle where EDGE_CNT == H+2 through the end of the bit.
- H+2 <= P-2 holds for every supported P, so the stop checker always sees the current bit's vote.
- Latency from the third sample to SAMPLED_BIT/SMP_VALID: 1 cycle.
- CNT_EN deassert: counters read 0 on the next cycle.
- CNT_EN assert: the first counted edge is EDGE_CNT=0 in that cycle, and EDGE_CNT=1 on the next cycle.
- Simultaneous BIT_CNT increment and CNT_EN=0: the clear wins.

## Structure
- Shared package uart_rx_pkg:
  - prescale constants PRESC_8/16/32
  - the prescale-decode function
  - the 3-input majority function
  - BIT_CNT width constant (4)
- Sub-module edge_bit_counter (EDGE_CNT, BIT_CNT, BIT_DONE, decoded P).
- The sampler/vote logic lives in the top.

## Test plan
- Reset: hold RST=0 with RX_IN=0, CNT_EN=SMP_EN=1 -> EDGE_CNT=0, BIT_CNT=0, SAMPLED_BIT=1, SMP_VALID=0 every cycle.
- P=8, RX_IN=0 constant, enables high:
  - EDGE_CNT cycles 0..7; BIT_DONE at 7; BIT_CNT 0->1.
  - SMP_VALID pulses with SAMPLED_BIT=0 first visible at EDGE_CNT=6.
  - SMP_NOISE=0.
- P=16, RX_IN=1 except 0 at EDGE_CNT=8 only -> samples 1,0,1; SAMPLED_BIT=1 at EDGE_CNT=10; SMP_NOISE pulses once.
- P=32, RX_IN=0 at EDGE_CNT 15 and 16, 1 elsewhere -> SAMPLED_BIT=0 visible at EDGE_CNT=18, SMP_NOISE=1. Run 17 bits -> BIT_CNT wraps 15->0.
- CNT_EN dropped at EDGE_CNT=5, BIT_CNT=3 -> next cycle both 0, SAMPLED_BIT unchanged, no SMP_VALID.
- PRESCALE=12 -> behaves exactly as P=8. Synchronous RST=0 at EDGE_CNT=4 mid-frame -> all outputs to reset values on the next edge; counting resumes from 0 after release.
